prog_rate_counter: RTL

//   Parametrised successor to the fixed 4-bit rate-divided display counter.
//   A programmable-period tick generator drives a WIDTH-bit modulo counter with
//   up/down count, pause, synchronous load and a wrap pulse.

---
 rtl/prog_rate_counter_pkg.sv | 26 ++
 rtl/rate_tick_gen.sv | 64 ++++++
 rtl/prog_rate_counter.sv | 77 +++++++
 3 files changed

// File: rtl/prog_rate_counter_pkg.sv
// Shared definitions for the programmable-rate counter: speed encodings,
// the tick period for each speed and the divider width needed to hold it.
package prog_rate_counter_pkg;

    // Speed select encodings (SPEED_W = 2)
    localparam int unsigned SPD_FAST = 0;  // one step per clock
    localparam int unsigned SPD_1X   = 1;  // CLOCK_FREQUENCY cycles
    localparam int unsigned SPD_2X   = 2;  // 2 * CLOCK_FREQUENCY cycles
    localparam int unsigned SPD_4X   = 3;  // 4 * CLOCK_FREQUENCY cycles

    // Tick period in clock cycles for speed s: 1 for s=0, else f << (s-1).
    function automatic int unsigned rate_period(input int unsigned s,
                                                input int unsigned clock_frequency);
        if (s == 0) begin
            return 1;
        end
        return clock_frequency << (s - 1);
    endfunction

    // Divider width wide enough for the longest period minus one, with headroom.
    function automatic int unsigned div_width(input int unsigned clock_frequency,
                                              input int unsigned speed_w);
        return $clog2(clock_frequency << ((2 ** speed_w) - 2)) + 1;
    endfunction

endpackage

// File: rtl/rate_tick_gen.sv
// Programmable-period step generator. A down-counting divider fires a
// one-cycle step when it reaches zero and reloads with P(speed)-1.
// Optional feature macro: PROG_RATE_COUNTER_SPEED_RESTART_EN -- when defined,
// a change on speed restarts the current period immediately at the new rate.
module rate_tick_gen
    import prog_rate_counter_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 100,
    parameter int unsigned SPEED_W         = 2,
    parameter int unsigned DIV_W           = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SPEED_W-1:0] speed,
    input  logic               pause,
    input  logic               load,
    output logic               step
);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] reload;
    logic             restart;

    // Reload value follows the live speed input; it is only used at a reload.
    assign reload = DIV_W'(rate_period(32'(speed), CLOCK_FREQUENCY) - 32'd1);

`ifdef PROG_RATE_COUNTER_SPEED_RESTART_EN
    logic [SPEED_W-1:0] speed_q;

    assign restart = (speed != speed_q);

    // Track the last seen speed so a change can be detected on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed_q <= '0;
        end else begin
            speed_q <= speed;
        end
    end
`else
    // Without restart, a new speed only takes effect at the next reload.
    assign restart = 1'b0;
`endif

    // A step needs an expired divider and no pause, load or restart this edge.
    assign step = (div == '0) && !pause && !load && !restart;

    // Divider: load and restart reload, pause holds, otherwise count down and
    // reload on expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (load || restart) begin
            div <= reload;
        end else if (!pause) begin
            if (div == '0) begin
                div <= reload;
            end else begin
                div <= div - DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/prog_rate_counter.sv
// Programmable-rate WIDTH-bit modulo counter with up/down count, pause,
// synchronous load (clamped to MAX_COUNT) and registered Tick/Wrap pulses.
// Optional feature macro: PROG_RATE_COUNTER_SPEED_RESTART_EN (see rate_tick_gen).
module prog_rate_counter
    import prog_rate_counter_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 100,
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned MAX_COUNT       = (2 ** WIDTH) - 1,
    parameter int unsigned SPEED_W         = 2
) (
    input  logic               ClockIn,
    input  logic               Reset,
    input  logic [SPEED_W-1:0] Speed,
    input  logic               Pause,
    input  logic               Up,
    input  logic               Load,
    input  logic [WIDTH-1:0]   LoadValue,
    output logic [WIDTH-1:0]   CounterValue,
    output logic               Tick,
    output logic               Wrap
);

    localparam int unsigned      DIV_W = div_width(CLOCK_FREQUENCY, SPEED_W);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    logic step;

    rate_tick_gen #(
        .CLOCK_FREQUENCY (CLOCK_FREQUENCY),
        .SPEED_W         (SPEED_W),
        .DIV_W           (DIV_W)
    ) u_tick_gen (
        .clk   (ClockIn),
        .rst   (Reset),
        .speed (Speed),
        .pause (Pause),
        .load  (Load),
        .step  (step)
    );

    // Counter with load priority; Tick/Wrap mark the cycle showing a stepped value.
    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            CounterValue <= '0;
            Tick         <= 1'b0;
            Wrap         <= 1'b0;
        end else if (Load) begin
            CounterValue <= (LoadValue > MAX_V) ? MAX_V : LoadValue;
            Tick         <= 1'b0;
            Wrap         <= 1'b0;
        end else if (step) begin
            Tick <= 1'b1;
            if (Up) begin
                if (CounterValue >= MAX_V) begin
                    CounterValue <= '0;
                    Wrap         <= 1'b1;
                end else begin
                    CounterValue <= CounterValue + WIDTH'(1);
                    Wrap         <= 1'b0;
                end
            end else begin
                if (CounterValue == '0) begin
                    CounterValue <= MAX_V;
                    Wrap         <= 1'b1;
                end else begin
                    CounterValue <= CounterValue - WIDTH'(1);
                    Wrap         <= 1'b0;
                end
            end
        end else begin
            Tick <= 1'b0;
            Wrap <= 1'b0;
        end
    end

endmodule
